// File: rtl/tick_timer.sv
// tick_timer: programmable tick prescaler with blink toggle and a tick-driven
// countdown timer used by the traffic-light phase FSM to time light phases.
//
// Strobe semantics: restart, period_load and timer_load are single-cycle
// strobes sampled on the rising clk edge; there is no back-pressure, every
// strobe is accepted on the edge it is seen. Any of them clears the
// prescaler and suppresses a tick on that edge. period_err and timer_done are
// one-cycle registered pulses; tick is a one-cycle registered pulse.
module tick_timer #(
  parameter int CNT_WIDTH      = 25,
  parameter int DEFAULT_PERIOD = 27_000_000,
  parameter int SEC_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 divider_reset_n,
  input  logic                 run,
  input  logic                 restart,
  input  logic [CNT_WIDTH-1:0] period_in,
  input  logic                 period_load,
  output logic                 period_err,
  output logic                 tick,
  output logic                 blink,
  input  logic [SEC_WIDTH-1:0] timer_value,
  input  logic                 timer_load,
  output logic                 timer_busy,
  output logic [SEC_WIDTH-1:0] timer_remaining,
  output logic                 timer_done,
  output logic                 timer_state
);

  localparam logic [CNT_WIDTH-1:0] DEF_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] MIN_PERIOD = CNT_WIDTH'(2);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic [SEC_WIDTH-1:0] rem_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 clear;
  logic                 term;

  // Any strobe restarts the prescaler so the next interval is a full period.
  assign clear = restart | period_load | timer_load;
  assign term  = run & (cnt_q == (period_q - CNT_WIDTH'(1))) & ~clear;

  // Debug view of the countdown FSM state.
  assign timer_state = (state_q == COUNT);

  // Prescaler count, period register, tick/blink and period error pulse.
  always_ff @(posedge clk or negedge divider_reset_n) begin
    if (!divider_reset_n) begin
      cnt_q      <= '0;
      period_q   <= DEF_PERIOD;
      tick       <= 1'b0;
      blink      <= 1'b0;
      period_err <= 1'b0;
    end else begin
      tick       <= 1'b0;
      period_err <= 1'b0;
      if (period_load) begin
        if (period_in >= MIN_PERIOD) begin
          period_q <= period_in;
        end else begin
          period_err <= 1'b1;
        end
      end
      if (clear) begin
        cnt_q <= '0;
      end else if (term) begin
        cnt_q <= '0;
        tick  <= 1'b1;
        blink <= ~blink;
      end else if (run) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Countdown FSM state and registered timer outputs.
  always_ff @(posedge clk or negedge divider_reset_n) begin
    if (!divider_reset_n) begin
      state_q         <= IDLE;
      timer_remaining <= '0;
      timer_busy      <= 1'b0;
      timer_done      <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_remaining <= rem_d;
      timer_busy      <= busy_d;
      timer_done      <= done_d;
    end
  end

  // Next-state logic: a load always wins; otherwise count down on ticks.
  always_comb begin
    state_d = state_q;
    rem_d   = timer_remaining;
    busy_d  = timer_busy;
    done_d  = 1'b0;
    if (timer_load) begin
      if (timer_value == '0) begin
        state_d = IDLE;
        rem_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = COUNT;
        rem_d   = timer_value;
        busy_d  = 1'b1;
      end
    end else if ((state_q == COUNT) && term) begin
      rem_d = timer_remaining - SEC_WIDTH'(1);
      if (timer_remaining == SEC_WIDTH'(1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: directed scenarios plus randomized stimulus for tick_timer,
// checked every cycle against a countdown-style reference model.
module tb_tick_timer;

  localparam int CW = 25;
  localparam int SW = 8;
  localparam int DEF_P = 4;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          restart;
  logic [CW-1:0] period_in;
  logic          period_load;
  logic          period_err;
  logic          tick;
  logic          blink;
  logic [SW-1:0] timer_value;
  logic          timer_load;
  logic          timer_busy;
  logic [SW-1:0] timer_remaining;
  logic          timer_done;
  logic          timer_state;

  int vectors;
  int miscompares;

  // Reference model state: cycles of running left until the next tick.
  int m_period;
  int m_left;
  int m_rem;
  bit m_tick, m_blink, m_err, m_busy, m_done;

  tick_timer #(
    .CNT_WIDTH(CW),
    .DEFAULT_PERIOD(DEF_P),
    .SEC_WIDTH(SW)
  ) dut (
    .clk(clk),
    .divider_reset_n(rst_n),
    .run(run),
    .restart(restart),
    .period_in(period_in),
    .period_load(period_load),
    .period_err(period_err),
    .tick(tick),
    .blink(blink),
    .timer_value(timer_value),
    .timer_load(timer_load),
    .timer_busy(timer_busy),
    .timer_remaining(timer_remaining),
    .timer_done(timer_done),
    .timer_state(timer_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_period = DEF_P;
    m_left   = DEF_P;
    m_rem    = 0;
    m_tick   = 0;
    m_blink  = 0;
    m_err    = 0;
    m_busy   = 0;
    m_done   = 0;
  endtask

  // One clock edge of behaviour, written from the tick-spacing rules.
  task automatic model_step();
    bit clr;
    bit fire;
    clr    = restart | period_load | timer_load;
    fire   = 0;
    m_tick = 0;
    m_err  = 0;
    m_done = 0;
    if (period_load) begin
      if (int'(period_in) >= 2) m_period = int'(period_in);
      else m_err = 1;
    end
    if (clr) begin
      m_left = m_period;
    end else if (run) begin
      m_left--;
      if (m_left == 0) begin
        fire   = 1;
        m_left = m_period;
      end
    end
    if (fire) begin
      m_tick  = 1;
      m_blink = ~m_blink;
    end
    if (timer_load) begin
      if (timer_value == 0) begin
        m_rem  = 0;
        m_busy = 0;
        m_done = 1;
      end else begin
        m_rem  = int'(timer_value);
        m_busy = 1;
      end
    end else if (m_busy && fire) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tick"},  32'(tick),            32'(m_tick));
    chk({tag, ".blink"}, 32'(blink),           32'(m_blink));
    chk({tag, ".perr"},  32'(period_err),      32'(m_err));
    chk({tag, ".busy"},  32'(timer_busy),      32'(m_busy));
    chk({tag, ".rem"},   32'(timer_remaining), 32'(m_rem));
    chk({tag, ".done"},  32'(timer_done),      32'(m_done));
    chk({tag, ".state"}, 32'(timer_state),     32'(m_busy));
  endtask

  // Driver: apply current inputs across one edge, check, then drop strobes.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    restart     = 1'b0;
    period_load = 1'b0;
    timer_load  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".tick"},  32'(tick),            0);
    chk({tag, ".blink"}, 32'(blink),           0);
    chk({tag, ".perr"},  32'(period_err),      0);
    chk({tag, ".busy"},  32'(timer_busy),      0);
    chk({tag, ".rem"},   32'(timer_remaining), 0);
    chk({tag, ".done"},  32'(timer_done),      0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    run         = 1'b1;
    restart     = 1'b0;
    period_in   = '0;
    period_load = 1'b0;
    timer_value = '0;
    timer_load  = 1'b0;
    model_reset();
    #12;
    check_reset_values("reset");
    rst_n = 1'b1;

    // 1: free-running ticks every 4 edges, blink toggles on each.
    for (int k = 1; k <= 12; k++) begin
      cycle("s1");
      chk("s1_tick_abs", 32'(tick), 32'((k % 4) == 0));
      chk("s1_blink_abs", 32'(blink), 32'((k / 4) % 2));
    end

    // 2: pause 3 cycles after edge 2 -> tick after edge 7.
    for (int k = 1; k <= 15; k++) begin
      run = !(k >= 3 && k <= 5);
      cycle("s2");
      if (k <= 7) chk("s2_tick_abs", 32'(tick), 32'(k == 7));
    end
    run = 1'b1;

    // 3: period 6, then a rejected period of 1.
    period_in   = CW'(6);
    period_load = 1'b1;
    cycle("s3_load");
    for (int k = 1; k <= 13; k++) begin
      cycle("s3");
      chk("s3_tick_abs", 32'(tick), 32'((k % 6) == 0));
    end
    period_in   = CW'(1);
    period_load = 1'b1;
    cycle("s3_bad");
    chk("s3_err_abs", 32'(period_err), 1);
    for (int k = 1; k <= 13; k++) cycle("s3b");
    period_in   = CW'(4);
    period_load = 1'b1;
    cycle("s3_back");

    // 4: countdown of 3 ticks.
    timer_value = SW'(3);
    timer_load  = 1'b1;
    cycle("s4_load");
    for (int k = 1; k <= 13; k++) begin
      cycle("s4");
      if (k == 12) chk("s4_done_abs", 32'(timer_done), 1);
      if (k == 12) chk("s4_busy_abs", 32'(timer_busy), 0);
    end

    // 5: reload 2 during a count of 5, then a zero-length load.
    timer_value = SW'(5);
    timer_load  = 1'b1;
    cycle("s5_load");
    for (int k = 1; k <= 5; k++) cycle("s5a");
    timer_value = SW'(2);
    timer_load  = 1'b1;
    cycle("s5_reload");
    for (int k = 1; k <= 9; k++) begin
      cycle("s5b");
      chk("s5_done_abs", 32'(timer_done), 32'(k == 8));
    end
    timer_value = SW'(0);
    timer_load  = 1'b1;
    cycle("s5_zero");
    chk("s5_zero_done", 32'(timer_done), 1);
    chk("s5_zero_busy", 32'(timer_busy), 0);

    // 6: async reset mid-count with no clock edge.
    timer_value = SW'(5);
    timer_load  = 1'b1;
    cycle("s6_load");
    for (int k = 1; k <= 5; k++) cycle("s6a");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("s6_async");
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle("s6b");
      chk("s6_tick_abs", 32'(tick), 32'(k == 4));
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 800; k++) begin
      run         = ($urandom_range(0, 7) != 0);
      restart     = ($urandom_range(0, 39) == 0);
      period_load = ($urandom_range(0, 49) == 0);
      period_in   = CW'($urandom_range(0, 7));
      timer_load  = ($urandom_range(0, 14) == 0);
      timer_value = SW'($urandom_range(0, 5));
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
